// File: rtl/canvas_write_arbiter_pkg.sv
// Shared canvas types: color encoding, layer numbers and the write-arbiter state set.
package canvas_write_arbiter_pkg;

  localparam int COLOR_WIDTH = 4;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = 4'h0;

  typedef logic [2:0] layer_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_CLEAR = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_t;

  // Layer numbers are 1-based; zero means "no layer".
  function automatic logic layer_in_range(input layer_t layer, input layer_t max_layer);
    return (layer != 3'd0) && (layer <= max_layer);
  endfunction

endpackage

// File: rtl/canvas_write_arbiter_raster_counter.sv
// Raster-order (x then y) pixel counter that drives the layer-clear sweep address.
module raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic                      last
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  // Sweep position: clear has priority, otherwise step one pixel per advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == Y_MAX) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = (r_x == X_MAX) && (r_y == Y_MAX);

endmodule

// File: rtl/canvas_write_arbiter.sv
// Single write port onto the canvas layers: merges freehand tool pixels with a
// whole-layer clear sweep and steers each write to one canvas via one-hot enable.
module canvas_write_arbiter
  import canvas_write_arbiter_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int NUM_LAYERS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tool_valid,
  input  logic [$clog2(WIDTH)-1:0]  tool_x,
  input  logic [$clog2(HEIGHT)-1:0] tool_y,
  input  logic [COLOR_WIDTH-1:0]    tool_color,
  input  layer_t                    tool_layer,
  input  logic [NUM_LAYERS-1:0]     layer_visible,
  input  logic                      clear_req,
  input  layer_t                    clear_layer,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      tool_drop,
  output logic [NUM_LAYERS-1:0]     wr_en,
  output logic [$clog2(WIDTH)-1:0]  wr_x,
  output logic [$clog2(HEIGHT)-1:0] wr_y,
  output logic [COLOR_WIDTH-1:0]    wr_color
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam layer_t        MAX_LAYER = layer_t'(NUM_LAYERS);
  localparam logic [XW:0]   X_LIM     = WIDTH[XW:0];
  localparam logic [YW:0]   Y_LIM     = HEIGHT[YW:0];

  arb_state_t               r_state;
  layer_t                   r_clear_layer;
  logic [NUM_LAYERS-1:0]    r_wr_en;
  logic [XW-1:0]            r_wr_x;
  logic [YW-1:0]            r_wr_y;
  logic [COLOR_WIDTH-1:0]   r_wr_color;
  logic                     r_clear_busy;
  logic                     r_clear_done;
  logic                     r_tool_drop;

  arb_state_t               w_state_nxt;
  logic [NUM_LAYERS-1:0]    w_tool_onehot;
  logic [NUM_LAYERS-1:0]    w_clear_onehot;
  logic                     w_tool_accept;
  logic                     w_clear_start;
  logic                     w_cnt_clear;
  logic                     w_cnt_advance;
  logic [XW-1:0]            w_cnt_x;
  logic [YW-1:0]            w_cnt_y;
  logic                     w_cnt_last;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_cnt_clear),
    .advance (w_cnt_advance),
    .x       (w_cnt_x),
    .y       (w_cnt_y),
    .last    (w_cnt_last)
  );

  // Layer decode; an out-of-range layer number decodes to all-zero.
  always_comb begin
    w_tool_onehot  = '0;
    w_clear_onehot = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_tool_onehot[i]  = (tool_layer == layer_t'(i + 1));
      w_clear_onehot[i] = (r_clear_layer == layer_t'(i + 1));
    end
  end

  // The layer being cleared is locked against tool writes until the sweep fully retires.
  always_comb begin
    w_tool_accept = tool_valid
                 && layer_in_range(tool_layer, MAX_LAYER)
                 && (|(w_tool_onehot & layer_visible))
                 && ({1'b0, tool_x} < X_LIM)
                 && ({1'b0, tool_y} < Y_LIM)
                 && !((r_state != ARB_IDLE) && (tool_layer == r_clear_layer));
    w_clear_start = clear_req && layer_in_range(clear_layer, MAX_LAYER);
    w_cnt_clear   = (r_state != ARB_CLEAR);
    w_cnt_advance = (r_state == ARB_CLEAR) && !w_tool_accept;
  end

  // Next-state logic; a stalled cycle never completes the sweep.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_clear_start) begin
          w_state_nxt = ARB_CLEAR;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_CLEAR: begin
        if (w_cnt_advance && w_cnt_last) begin
          w_state_nxt = ARB_DONE;
        end else begin
          w_state_nxt = ARB_CLEAR;
        end
      end
      ARB_DONE: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State register and the latched clear target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ARB_IDLE;
      r_clear_layer <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ARB_IDLE) && w_clear_start) begin
        r_clear_layer <= clear_layer;
      end
    end
  end

  // Registered write port: an accepted tool pixel wins, else the sweep writes COLOR_NONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en      <= '0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_wr_color   <= COLOR_NONE;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
      r_tool_drop  <= 1'b0;
    end else begin
      r_wr_en      <= '0;
      r_tool_drop  <= tool_valid && !w_tool_accept;
      r_clear_done <= (r_state == ARB_DONE);
      r_clear_busy <= (w_state_nxt != ARB_IDLE);
      if (w_tool_accept) begin
        r_wr_en    <= w_tool_onehot;
        r_wr_x     <= tool_x;
        r_wr_y     <= tool_y;
        r_wr_color <= tool_color;
      end else if (r_state == ARB_CLEAR) begin
        r_wr_en    <= w_clear_onehot;
        r_wr_x     <= w_cnt_x;
        r_wr_y     <= w_cnt_y;
        r_wr_color <= COLOR_NONE;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_x       = r_wr_x;
  assign wr_y       = r_wr_y;
  assign wr_color   = r_wr_color;
  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;
  assign tool_drop  = r_tool_drop;

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Directed + randomized bench for canvas_write_arbiter on an 8x8, 4-layer canvas,
// checked every cycle against a pixel-index reference model.
module tb_canvas_write_arbiter;
  import canvas_write_arbiter_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NL = 4;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b1;
  logic                   tool_valid = 1'b0;
  logic [2:0]             tool_x = 3'd0;
  logic [2:0]             tool_y = 3'd0;
  logic [COLOR_WIDTH-1:0] tool_color = 4'd0;
  logic [2:0]             tool_layer = 3'd0;
  logic [NL-1:0]          layer_visible = 4'hF;
  logic                   clear_req = 1'b0;
  logic [2:0]             clear_layer = 3'd0;
  logic                   clear_busy;
  logic                   clear_done;
  logic                   tool_drop;
  logic [NL-1:0]          wr_en;
  logic [2:0]             wr_x;
  logic [2:0]             wr_y;
  logic [COLOR_WIDTH-1:0] wr_color;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a clear is "active" from start until its done pulse; m_idx counts swept pixels.
  bit         m_active = 1'b0;
  int         m_idx    = 0;
  logic [2:0] m_layer  = 3'd0;

  int cnt_wr   = 0;
  int cnt_done = 0;
  int cnt_l1   = 0;

  always #5 clk = ~clk;

  canvas_write_arbiter #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .NUM_LAYERS (NL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tool_valid    (tool_valid),
    .tool_x        (tool_x),
    .tool_y        (tool_y),
    .tool_color    (tool_color),
    .tool_layer    (tool_layer),
    .layer_visible (layer_visible),
    .clear_req     (clear_req),
    .clear_layer   (clear_layer),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .tool_drop     (tool_drop),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_color      (wr_color)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict from the model, sample 1 time unit after the edge.
  task automatic cyc(input logic tv, input logic [2:0] tx, input logic [2:0] ty,
                     input logic [3:0] tc, input logic [2:0] tl, input logic [3:0] vis,
                     input logic cr, input logic [2:0] cl);
    logic [3:0] e_en;
    logic [2:0] e_x;
    logic [2:0] e_y;
    logic [3:0] e_c;
    bit         acc;
    bit         fin;
    tool_valid    = tv;
    tool_x        = tx;
    tool_y        = ty;
    tool_color    = tc;
    tool_layer    = tl;
    layer_visible = vis;
    clear_req     = cr;
    clear_layer   = cl;
    acc = 1'b0;
    if (tv && int'(tl) >= 1 && int'(tl) <= NL) begin
      acc = vis[int'(tl) - 1] && !(m_active && tl == m_layer);
    end
    fin  = m_active && (m_idx == W * H);
    e_en = 4'd0;
    e_x  = 3'd0;
    e_y  = 3'd0;
    e_c  = COLOR_NONE;
    if (acc) begin
      e_en = 4'b0001 << (int'(tl) - 1);
      e_x  = tx;
      e_y  = ty;
      e_c  = tc;
    end else if (m_active && m_idx < W * H) begin
      e_en = 4'b0001 << (int'(m_layer) - 1);
      e_x  = 3'(m_idx % W);
      e_y  = 3'(m_idx / W);
      m_idx++;
    end
    if (fin) begin
      m_active = 1'b0;
      m_idx    = 0;
    end else if (!m_active && cr && int'(cl) >= 1 && int'(cl) <= NL) begin
      m_active = 1'b1;
      m_layer  = cl;
      m_idx    = 0;
    end
    @(posedge clk);
    #1;
    check("wr_en", 32'(wr_en), 32'(e_en));
    if (e_en != 4'd0) begin
      check("wr_x", 32'(wr_x), 32'(e_x));
      check("wr_y", 32'(wr_y), 32'(e_y));
      check("wr_color", 32'(wr_color), 32'(e_c));
    end
    check("tool_drop", 32'(tool_drop), 32'(tv && !acc));
    check("clear_done", 32'(clear_done), 32'(fin));
    check("clear_busy", 32'(clear_busy), 32'(m_active));
    if (wr_en != 4'd0) cnt_wr++;
    if (wr_en == 4'b0001) cnt_l1++;
    if (clear_done) cnt_done++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b0, 3'd0);
  endtask

  task automatic clear_counts();
    cnt_wr   = 0;
    cnt_done = 0;
    cnt_l1   = 0;
  endtask

  // Run idle cycles until a done pulse is seen, bounded so a stuck sweep still ends.
  task automatic run_to_done(input string tag);
    for (int i = 0; i < 200 && cnt_done == 0; i++) idle(1);
    check({tag, "_done_seen"}, 32'(cnt_done), 32'd1);
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_busy"}, 32'(clear_busy), 32'd0);
    check({tag, "_done"}, 32'(clear_done), 32'd0);
    check({tag, "_drop"}, 32'(tool_drop), 32'd0);
    check({tag, "_color"}, 32'(wr_color), 32'(COLOR_NONE));
    m_active = 1'b0;
    m_idx    = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    pulse_reset("rst_init");
    @(posedge clk);
    #1;

    // Tool write to a visible layer, then the same pixel with that layer hidden.
    cyc(1'b1, 3'd3, 3'd5, 4'd5, 3'd2, 4'hF, 1'b0, 3'd0);
    cyc(1'b1, 3'd3, 3'd5, 4'd5, 3'd2, 4'b1101, 1'b0, 3'd0);
    cyc(1'b1, 3'd1, 3'd1, 4'd9, 3'd0, 4'hF, 1'b0, 3'd0);
    cyc(1'b1, 3'd7, 3'd7, 4'd3, 3'd5, 4'hF, 1'b0, 3'd0);
    cyc(1'b1, 3'd7, 3'd0, 4'hE, 3'd4, 4'hF, 1'b0, 3'd0);

    // Out-of-range clear layers are ignored.
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd0);
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd5);
    idle(3);

    // Plain clear of layer 1.
    clear_counts();
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd1);
    run_to_done("clr1");
    idle(3);
    check("clr1_writes", 32'(cnt_l1), 32'd64);
    check("clr1_one_done", 32'(cnt_done), 32'd1);

    // Tool on layer 3 stalls the sweep for three cycles.
    clear_counts();
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd1);
    idle(10);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
          3'd3, 4'hF, 1'b0, 3'd0);
    run_to_done("stall");
    check("stall_total_writes", 32'(cnt_wr), 32'd67);
    check("stall_layer1_writes", 32'(cnt_l1), 32'd64);

    // Tool on the layer being cleared is dropped; a second request mid-sweep is ignored.
    clear_counts();
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd1);
    idle(5);
    cyc(1'b1, 3'd2, 3'd2, 4'd7, 3'd1, 4'hF, 1'b0, 3'd0);
    cyc(1'b1, 3'd4, 3'd6, 4'd8, 3'd1, 4'hF, 1'b1, 3'd2);
    cyc(1'b1, 3'd5, 3'd1, 4'd2, 3'd1, 4'hF, 1'b0, 3'd0);
    run_to_done("lock");
    idle(3);
    check("lock_layer1_writes", 32'(cnt_l1), 32'd64);
    check("lock_one_done", 32'(cnt_done), 32'd1);
    check("lock_total_writes", 32'(cnt_wr), 32'd64);

    // Reset after 20 clear writes aborts; a new request restarts at (0,0).
    clear_counts();
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd2);
    idle(20);
    check("abort_writes_before", 32'(cnt_wr), 32'd20);
    pulse_reset("rst_mid");
    idle(3);
    check("abort_no_done", 32'(cnt_done), 32'd0);
    clear_counts();
    cyc(1'b0, 3'd0, 3'd0, 4'd0, 3'd0, 4'hF, 1'b1, 3'd2);
    run_to_done("restart");
    check("restart_writes", 32'(cnt_wr), 32'd64);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 5)));
    end
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
